// File: rtl/match_controller.sv
// match_controller: two-innings T20 scoring state machine.
// Each ball_valid pulse is one scored delivery. The block tracks runs,
// wickets, overs and balls, moves through the innings, and declares the
// result. All registered state updates one cycle after the input pulse.
// Optional feature macro: FREE_HIT_EN. When it is defined, the delivery
// after a wide/no-ball is a free hit. When it is undefined, free_hit is
// held at 0 and every wicket counts.
module match_controller #(
    parameter int OVERS          = 20,
    parameter int BALLS_PER_OVER = 6,
    parameter int MAX_WICKETS    = 10,
    parameter int SCORE_W        = 9
) (
    input  logic               clk_fpga,
    input  logic               rst_n,
    input  logic               start,
    input  logic               ball_valid,
    input  logic [2:0]         ball_runs,
    input  logic               ball_wicket,
    input  logic               ball_extra,
    output logic [1:0]         innings,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic [3:0]         wickets,
    output logic [4:0]         overs,
    output logic [2:0]         balls,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               free_hit
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INN1,
        S_BREAK,
        S_INN2,
        S_DONE
    } state_t;

    state_t             state_reg, state_next;
    logic [SCORE_W-1:0] score1_reg, score1_next;
    logic [SCORE_W-1:0] score2_reg, score2_next;
    logic [3:0]         wickets_reg, wickets_next;
    logic [4:0]         overs_reg, overs_next;
    logic [2:0]         balls_reg, balls_next;
    logic [1:0]         winner_reg, winner_next;
    logic               free_hit_reg, free_hit_next;

    logic [2:0]         runs_eff;
    logic [3:0]         ball_total;
    logic               wicket_counts;
    logic               innings_end;

    // A 7 on the runs bus is clamped to 6; an extra adds one penalty run.
    assign runs_eff   = (ball_runs == 3'd7) ? 3'd6 : ball_runs;
    assign ball_total = {1'b0, runs_eff} + {3'b000, ball_extra};

`ifdef FREE_HIT_EN
    // On a free hit, a wicket on a legal ball does not count. A wicket on
    // another extra still counts.
    assign wicket_counts = ball_wicket && !(free_hit_reg && !ball_extra);
`else
    assign wicket_counts = ball_wicket;
`endif

    // Add runs to a score and stop at all-ones instead of wrapping.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [3:0] a);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W-3){1'b0}}, a};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    // Next-state and next-counter logic. The end of an innings is judged
    // on the post-ball counter values, so the last ball and the state
    // change land on the same clock edge.
    always_comb begin
        state_next    = state_reg;
        score1_next   = score1_reg;
        score2_next   = score2_reg;
        wickets_next  = wickets_reg;
        overs_next    = overs_reg;
        balls_next    = balls_reg;
        winner_next   = winner_reg;
        free_hit_next = free_hit_reg;
        innings_end   = 1'b0;

        case (state_reg)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_next    = S_INN1;
                    score1_next   = '0;
                    score2_next   = '0;
                    wickets_next  = '0;
                    overs_next    = '0;
                    balls_next    = '0;
                    winner_next   = 2'b00;
                    free_hit_next = 1'b0;
                end
            end

            S_INN1, S_INN2: begin
                if (ball_valid) begin
                    if (state_reg == S_INN1) begin
                        score1_next = sat_add(score1_reg, ball_total);
                    end else begin
                        score2_next = sat_add(score2_reg, ball_total);
                    end

                    if (!ball_extra) begin
                        if (balls_reg == 3'(BALLS_PER_OVER - 1)) begin
                            balls_next = '0;
                            overs_next = overs_reg + 5'd1;
                        end else begin
                            balls_next = balls_reg + 3'd1;
                        end
                    end

                    if (wicket_counts) begin
                        wickets_next = wickets_reg + 4'd1;
                    end

`ifdef FREE_HIT_EN
                    // An extra arms the free hit. A legal ball uses it up.
                    free_hit_next = ball_extra;
`else
                    free_hit_next = 1'b0;
`endif

                    innings_end = (wickets_next == 4'(MAX_WICKETS)) ||
                                  (overs_next == 5'(OVERS)) ||
                                  ((state_reg == S_INN2) && (score2_next > score1_reg));

                    if (innings_end) begin
                        free_hit_next = 1'b0;
                        if (state_reg == S_INN1) begin
                            state_next = S_BREAK;
                        end else begin
                            state_next = S_DONE;
                            if (score2_next > score1_reg) begin
                                winner_next = 2'b10;
                            end else if (score1_reg > score2_next) begin
                                winner_next = 2'b01;
                            end else begin
                                winner_next = 2'b11;
                            end
                        end
                    end
                end
            end

            // The first-innings figures stay on the display through the
            // break. They are cleared when the chase begins.
            S_BREAK: begin
                if (start) begin
                    state_next    = S_INN2;
                    wickets_next  = '0;
                    overs_next    = '0;
                    balls_next    = '0;
                    free_hit_next = 1'b0;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State and counter registers. Reset aborts a match immediately.
    always_ff @(posedge clk_fpga or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_IDLE;
            score1_reg   <= '0;
            score2_reg   <= '0;
            wickets_reg  <= '0;
            overs_reg    <= '0;
            balls_reg    <= '0;
            winner_reg   <= 2'b00;
            free_hit_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            score1_reg   <= score1_next;
            score2_reg   <= score2_next;
            wickets_reg  <= wickets_next;
            overs_reg    <= overs_next;
            balls_reg    <= balls_next;
            winner_reg   <= winner_next;
            free_hit_reg <= free_hit_next;
        end
    end

    // Innings code for the display. The break still reports innings 1,
    // because the second innings has not started yet.
    always_comb begin
        case (state_reg)
            S_INN1, S_BREAK: innings = 2'd1;
            S_INN2:          innings = 2'd2;
            S_DONE:          innings = 2'd3;
            default:         innings = 2'd0;
        endcase
    end

    assign score1    = score1_reg;
    assign score2    = score2_reg;
    assign wickets   = wickets_reg;
    assign overs     = overs_reg;
    assign balls     = balls_reg;
    assign game_over = (state_reg == S_DONE);
    assign winner    = winner_reg;
    assign free_hit  = free_hit_reg;

endmodule

// File: tb/tb_match_controller.sv
// Directed testbench for match_controller. It drives two instances from
// the same inputs: one with the default wicket limit and one with
// MAX_WICKETS=2. Both instances use OVERS=1 and six balls per over.
module tb_match_controller;

    logic       clk_fpga = 1'b0;
    logic       rst_n    = 1'b0;
    logic       start    = 1'b0;
    logic       ball_valid = 1'b0;
    logic [2:0] ball_runs  = 3'd0;
    logic       ball_wicket = 1'b0;
    logic       ball_extra  = 1'b0;

    logic [1:0] innings,  innings_w;
    logic [8:0] score1,   score1_w;
    logic [8:0] score2,   score2_w;
    logic [3:0] wickets,  wickets_w;
    logic [4:0] overs,    overs_w;
    logic [2:0] balls,    balls_w;
    logic       game_over, game_over_w;
    logic [1:0] winner,   winner_w;
    logic       free_hit, free_hit_w;

    int checks = 0;
    int errors = 0;

    always #5 clk_fpga = ~clk_fpga;

    match_controller #(.OVERS(1), .BALLS_PER_OVER(6), .MAX_WICKETS(10), .SCORE_W(9)) dut (
        .clk_fpga(clk_fpga), .rst_n(rst_n), .start(start), .ball_valid(ball_valid),
        .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
        .innings(innings), .score1(score1), .score2(score2), .wickets(wickets),
        .overs(overs), .balls(balls), .game_over(game_over), .winner(winner),
        .free_hit(free_hit)
    );

    match_controller #(.OVERS(1), .BALLS_PER_OVER(6), .MAX_WICKETS(2), .SCORE_W(9)) dut_w (
        .clk_fpga(clk_fpga), .rst_n(rst_n), .start(start), .ball_valid(ball_valid),
        .ball_runs(ball_runs), .ball_wicket(ball_wicket), .ball_extra(ball_extra),
        .innings(innings_w), .score1(score1_w), .score2(score2_w), .wickets(wickets_w),
        .overs(overs_w), .balls(balls_w), .game_over(game_over_w), .winner(winner_w),
        .free_hit(free_hit_w)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // One delivery: inputs are held from one falling edge to the next, so
    // exactly one rising edge sees them. The task returns at the falling
    // edge that follows that rising edge, where the result can be sampled.
    task automatic ball(input logic [2:0] r, input logic w, input logic e);
        @(negedge clk_fpga);
        ball_valid = 1'b1; ball_runs = r; ball_wicket = w; ball_extra = e;
        $display("ball runs=%0d wicket=%0d extra=%0d", r, w, e);
        @(negedge clk_fpga);
        ball_valid = 1'b0; ball_runs = 3'd0; ball_wicket = 1'b0; ball_extra = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk_fpga);
        start = 1'b1;
        $display("start");
        @(negedge clk_fpga);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk_fpga);
        rst_n = 1'b0;
        @(negedge clk_fpga);
        rst_n = 1'b1;
        $display("reset");
    endtask

    initial begin
        // Check the reset state.
        @(negedge clk_fpga);
        @(negedge clk_fpga);
        rst_n = 1'b1;
        check("rst_innings", 32'(innings), 0);
        check("rst_score1", 32'(score1), 0);
        check("rst_score2", 32'(score2), 0);
        check("rst_wkts_overs_balls", {wickets, overs, balls}, 0);
        check("rst_go_win_fh", {game_over, winner, free_hit}, 0);

        // Test 1: six legal fours end innings 1 at OVERS=1.
        pulse_start();
        check("t1_innings1", 32'(innings), 1);
        for (int i = 0; i < 5; i++) ball(3'd4, 1'b0, 1'b0);
        check("t1_score20", 32'(score1), 20);
        check("t1_balls5", 32'(balls), 5);
        ball(3'd4, 1'b0, 1'b0);
        check("t1_score24", 32'(score1), 24);
        check("t1_break_no_go", 32'(game_over), 0);
        ball(3'd4, 1'b0, 1'b0);               // ignored in BREAK
        check("t1_break_ignore", 32'(score1), 24);
        pulse_start();
        check("t1_innings2", 32'(innings), 2);
        check("t1_overs_balls_clr", {overs, balls}, 0);
        check("t1_score2_zero", 32'(score2), 0);

        // Test 3 variant: a chase of 24 that ties. A 7 on the runs bus counts as 6.
        for (int i = 0; i < 4; i++) ball(3'd7, 1'b0, 1'b0);
        check("t3_score2_24", 32'(score2), 24);
        check("t3_not_over", 32'(game_over), 0);
        ball(3'd0, 1'b0, 1'b0);
        ball(3'd0, 1'b0, 1'b0);
        check("t3_tie_winner", 32'(winner), 3);
        check("t3_game_over", 32'(game_over), 1);
        check("t3_innings3", 32'(innings), 3);
        ball(3'd4, 1'b0, 1'b0);               // ignored in DONE
        check("t3_done_ignore", 32'(score2), 24);
        pulse_start();
        check("t3_new_game", {innings, game_over, winner}, {2'd1, 1'b0, 2'd0});
        check("t3_new_scores", {score1, score2}, 0);

        // Test 2: innings 1 makes 10; the chase wins on its 2nd ball.
        ball(3'd3, 1'b1, 1'b0);               // run-out with 3 runs
        check("t2_runout", {score1, wickets, balls}, {9'd3, 4'd1, 3'd1});
        ball(3'd0, 1'b0, 1'b1);               // wide
        check("t2_wide", {score1, balls}, {9'd4, 3'd1});
        ball(3'd6, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) ball(3'd0, 1'b0, 1'b0);
        check("t2_score1_10", 32'(score1), 10);
        pulse_start();
        check("t2_inn2_clear", {innings, wickets}, {2'd2, 4'd0});
        ball(3'd6, 1'b0, 1'b0);
        check("t2_score2_6", {score2, innings}, {9'd6, 2'd2});
        ball(3'd5, 1'b0, 1'b0);
        check("t2_score2_11", 32'(score2), 11);
        check("t2_winner_team2", {game_over, winner, innings}, {1'b1, 2'b10, 2'd3});
        ball(3'd4, 1'b0, 1'b0);
        check("t2_after_done", 32'(score2), 11);

        // start together with ball_valid in DONE: the new game starts and the ball is dropped.
        @(negedge clk_fpga);
        start = 1'b1; ball_valid = 1'b1; ball_runs = 3'd4;
        $display("start+ball runs=4");
        @(negedge clk_fpga);
        start = 1'b0; ball_valid = 1'b0; ball_runs = 3'd0;
        check("sim_start_ball", {innings, score1}, {2'd1, 9'd0});

        // Score saturation: 80 wides of 6+1 would reach 560; the score stops at 511.
        for (int i = 0; i < 80; i++) ball(3'd6, 1'b0, 1'b1);
        check("sat_score1", 32'(score1), 511);
        check("sat_still_inn1", {innings, balls}, {2'd1, 3'd0});

        // Test 5: reset during innings 2.
        for (int i = 0; i < 6; i++) ball(3'd0, 1'b0, 1'b0);
        pulse_start();
        ball(3'd2, 1'b0, 1'b0);
        check("t5_mid_inn2", {innings, score2}, {2'd2, 9'd2});
        @(negedge clk_fpga);
        rst_n = 1'b0;
        #1;
        check("t5_async_clear", {innings, score1, score2, wickets, overs, balls},
              0);
        check("t5_async_flags", {game_over, winner, free_hit}, 0);
        @(negedge clk_fpga);
        rst_n = 1'b1;
        ball(3'd4, 1'b0, 1'b0);
        check("t5_no_start_ignore", {innings, score1}, 0);

        // Test 4: with MAX_WICKETS=2, the second wicket (off a wide) ends the innings.
        pulse_start();
        ball(3'd2, 1'b1, 1'b0);
        check("t4_first_wkt", {score1_w, wickets_w, balls_w}, {9'd2, 4'd1, 3'd1});
        ball(3'd0, 1'b1, 1'b1);
        check("t4_score3", 32'(score1_w), 3);
        check("t4_wkts_balls", {wickets_w, balls_w}, {4'd2, 3'd1});
        ball(3'd4, 1'b0, 1'b0);               // BREAK ignores balls
        check("t4_break_ignore", 32'(score1_w), 3);
        pulse_start();
        check("t4_inn2", {innings_w, wickets_w}, {2'd2, 4'd0});

        // Test 6: free hit after a wide.
        do_reset();
        pulse_start();
        ball(3'd0, 1'b0, 1'b1);
`ifdef FREE_HIT_EN
        check("t6_fh_set", 32'(free_hit), 1);
`else
        check("t6_fh_tied", 32'(free_hit), 0);
`endif
        check("t6_wide_score", 32'(score1), 1);
        ball(3'd1, 1'b1, 1'b0);
        check("t6_score2", 32'(score1), 2);
        check("t6_fh_clear", 32'(free_hit), 0);
`ifdef FREE_HIT_EN
        check("t6_wkt_ignored", 32'(wickets), 0);
`else
        check("t6_wkt_counts", 32'(wickets), 1);
`endif
        ball(3'd0, 1'b1, 1'b0);
`ifdef FREE_HIT_EN
        check("t6_next_wkt", 32'(wickets), 1);
`else
        check("t6_next_wkt", 32'(wickets), 2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
